mandel_pixel_writer: RTL and testbench



---
 rtl/mandel_pixel_writer.sv | 129 ++++++++++++
 tb/tb_mandel_pixel_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_pixel_writer.sv
// Mandelbrot result packer: colour-maps (x, y, iter) into 32-bit words, buffers them, and
// streams them out as Avalon-MM writes. Define MANDEL_WR_DROP_CNT_EN to count out-of-range drops.
module mandel_pixel_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ITER_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  input  logic [ITER_W-1:0] in_iter,
  input  logic [ITER_W-1:0] max_iter,
  output logic [31:0]       avm_m0_writedata,
  output logic              avm_m0_write,
  input  logic              avm_m0_waitrequest,
  output logic              frame_done,
  output logic [19:0]       pixel_count,
  output logic [15:0]       drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state, state_n;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          in_range, take, push, pop, accept, last_word;
  logic [11:0]   rgb;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full && !rst;

  assign in_range = (in_x <= X_LAST) && (in_y <= Y_LAST);
  assign take     = in_valid && in_ready;
  assign push     = take && in_range;

  always_comb begin
    rgb = '0;
    if (in_iter < max_iter)
      rgb = {in_iter[3:0], in_iter[ITER_W-1 -: 4], ~in_iter[3:0]};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {in_y, in_x, rgb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign avm_m0_write = (state == WRITE);
  assign accept       = avm_m0_write && !avm_m0_waitrequest;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      avm_m0_writedata <= '0;
    end else begin
      state <= state_n;
      if (pop)
        avm_m0_writedata <= mem[rptr];
    end
  end

  // The last pixel of the frame clears the count instead of incrementing it.
  assign last_word  = (avm_m0_writedata[31:22] == Y_LAST) && (avm_m0_writedata[21:12] == X_LAST);
  assign frame_done = accept && last_word;

  always_ff @(posedge clk) begin
    if (rst)             pixel_count <= '0;
    else if (frame_done) pixel_count <= '0;
    else if (accept)     pixel_count <= pixel_count + 20'd1;
  end

`ifdef MANDEL_WR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= '0;
    else if (take && !in_range && (drop_count != '1))
      drop_count <= drop_count + 16'd1;
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Directed bench for mandel_pixel_writer: vector table, backpressure, mid-write reset,
// and a full-frame run on a reduced-raster instance.
module tb_mandel_pixel_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic [9:0]  in_x, in_y;
  logic [7:0]  in_iter, max_iter;
  logic [31:0] wd;
  logic        wr, wreq, fd;
  logic [19:0] pc;
  logic [15:0] dc;

  logic        f_valid, f_ready;
  logic [9:0]  f_x, f_y;
  logic [7:0]  f_iter, f_max;
  logic [31:0] f_wd;
  logic        f_wr, f_wreq, f_fd;
  logic [19:0] f_pc;
  logic [15:0] f_dc;

  mandel_pixel_writer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_iter(in_iter), .max_iter(max_iter),
    .avm_m0_writedata(wd), .avm_m0_write(wr), .avm_m0_waitrequest(wreq),
    .frame_done(fd), .pixel_count(pc), .drop_count(dc)
  );

  mandel_pixel_writer #(.H_ACTIVE(8), .V_ACTIVE(4), .ITER_W(8), .FIFO_DEPTH(4)) u_frm (
    .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(f_ready),
    .in_x(f_x), .in_y(f_y), .in_iter(f_iter), .max_iter(f_max),
    .avm_m0_writedata(f_wd), .avm_m0_write(f_wr), .avm_m0_waitrequest(f_wreq),
    .frame_done(f_fd), .pixel_count(f_pc), .drop_count(f_dc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [9:0] x, input logic [9:0] y,
                                       input logic [7:0] it, input logic [7:0] mx);
    logic [11:0] c;
    c = (it >= mx) ? 12'h000 : {it[3:0], it[7:4], ~it[3:0]};
    return {y, x, c};
  endfunction

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  iter;
    logic [7:0]  mx;
    logic        drop;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_pc, exp_dc, lat, bad;
    int first_low, stable_bad, nwr, nfd, post, guard;
    logic fd_ok, r, prev_wr, prev_wait;
    logic [31:0] prev_wd;
    logic [31:0] got[$];
    int acc_cyc[$];

    vecs[0] = '{x:10'd5,   y:10'd3,    iter:8'h2A, mx:8'hFF, drop:1'b0, data:32'h00C05A25};
    vecs[1] = '{x:10'd1,   y:10'd1,    iter:8'h40, mx:8'h40, drop:1'b0, data:32'h00401000};
    vecs[2] = '{x:10'd2,   y:10'd2,    iter:8'h41, mx:8'h40, drop:1'b0, data:32'h00802000};
    vecs[3] = '{x:10'd639, y:10'd479,  iter:8'h3C, mx:8'h80, drop:1'b0, data:32'h77E7FC33};
    vecs[4] = '{x:10'd640, y:10'd0,    iter:8'h11, mx:8'hFF, drop:1'b1, data:32'h0};
    vecs[5] = '{x:10'd0,   y:10'd480,  iter:8'h11, mx:8'hFF, drop:1'b1, data:32'h0};
    vecs[6] = '{x:10'd1023, y:10'd1023, iter:8'h11, mx:8'hFF, drop:1'b1, data:32'h0};
    vecs[7] = '{x:10'd0,   y:10'd0,    iter:8'h00, mx:8'h01, drop:1'b0, data:32'h0000000F};
    vecs[8] = '{x:10'd10,  y:10'd20,   iter:8'hFF, mx:8'hFF, drop:1'b0, data:32'h0500A000};
    vecs[9] = '{x:10'd100, y:10'd200,  iter:8'h9E, mx:8'hFF, drop:1'b0, data:32'h32064E91};

    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_iter = '0; max_iter = '0; wreq = 1'b0;
    f_valid = 1'b0;  f_x = '0;  f_y = '0;  f_iter = '0;  f_max = 8'hFF;  f_wreq = 1'b0;
    exp_pc = 0; exp_dc = 0;

    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_write", wr, 0);
    check("reset_writedata", wd, 0);
    check("reset_frame_done", fd, 0);
    check("reset_pixel_count", pc, 0);
    check("reset_drop_count", dc, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_x = vecs[i].x; in_y = vecs[i].y; in_iter = vecs[i].iter; max_iter = vecs[i].mx;
      @(negedge clk);
      in_valid = 1'b0;
      if (!vecs[i].drop) begin
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
          if (wr) begin
            lat = c;
            break;
          end
          @(negedge clk);
        end
        check($sformatf("v%0d_latency", i), lat, 2);
        check($sformatf("v%0d_writedata", i), wd, vecs[i].data);
        check($sformatf("v%0d_frame_done", i), fd,
              (vecs[i].x == 10'd639 && vecs[i].y == 10'd479) ? 1 : 0);
        exp_pc = (vecs[i].x == 10'd639 && vecs[i].y == 10'd479) ? 0 : exp_pc + 1;
        @(negedge clk);
        check($sformatf("v%0d_pixel_count", i), pc, exp_pc);
        check($sformatf("v%0d_write_idle", i), wr, 0);
      end else begin
        bad = 0;
        repeat (3) begin
          if (wr || !in_ready) bad = 1;
          @(negedge clk);
        end
        check($sformatf("v%0d_drop_no_write", i), bad, 0);
`ifdef MANDEL_WR_DROP_CNT_EN
        exp_dc++;
`endif
        check($sformatf("v%0d_drop_count", i), dc, exp_dc);
      end
    end

    // Backpressure: 6 pixels against a slave stalled for the first 10 cycles.
    first_low = -1; stable_bad = 0;
    prev_wr = 1'b0; prev_wait = 1'b0; prev_wd = '0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          in_valid = 1'b1;
          in_x = 10'(i); in_y = 10'd7; in_iter = 8'(i * 16 + 1); max_iter = 8'hFF;
          guard = 0;
          do begin
            r = in_ready;
            if (!r && first_low < 0) first_low = i;
            @(negedge clk);
            guard++;
          end while (!r && guard < 50);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          wreq = (c < 10);
          if (wr) begin
            if (prev_wr && prev_wait && wd != prev_wd) stable_bad++;
            if (!wreq) begin
              got.push_back(wd);
              acc_cyc.push_back(c);
            end
          end
          prev_wr = wr; prev_wait = wreq; prev_wd = wd;
          @(negedge clk);
        end
        wreq = 1'b0;
      end
    join
    check("bp_ready_low_after", first_low, 5);
    check("bp_stall_stable", stable_bad, 0);
    check("bp_word_count", got.size(), 6);
    if (got.size() == 6) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("bp_word%0d", k), got[k], pack(10'(k), 10'd7, 8'(k * 16 + 1), 8'hFF));
      check("bp_first_accept_cycle", acc_cyc[0], 10);
      check("bp_back_to_back", acc_cyc[5] - acc_cyc[0], 5);
    end
    exp_pc += 6;
    check("bp_pixel_count", pc, exp_pc);

    // Reset while a write is stalled with another word queued.
    wreq = 1'b1;
    in_valid = 1'b1; in_x = 10'd3; in_y = 10'd3; in_iter = 8'h12; max_iter = 8'hFF;
    @(negedge clk);
    in_x = 10'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mr_write_stalled", wr, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_write_dropped", wr, 0);
    check("mr_in_ready_in_reset", in_ready, 0);
    rst = 1'b0;
    wreq = 1'b0;
    @(negedge clk);
    check("mr_in_ready_after", in_ready, 1);
    bad = 0;
    repeat (4) begin
      if (wr) bad = 1;
      @(negedge clk);
    end
    check("mr_fifo_flushed", bad, 0);
    check("mr_pixel_count", pc, 0);
    check("mr_drop_count", dc, 0);

    // Full 8x4 frame on the reduced instance with random waitrequest.
    nwr = 0; nfd = 0; post = 0; fd_ok = 1'b0;
    fork
      begin
        for (int y = 0; y < 4; y++) begin
          for (int x = 0; x < 8; x++) begin
            f_valid = 1'b1;
            f_x = 10'(x); f_y = 10'(y); f_iter = 8'(x * 8 + y); f_max = 8'hFF;
            guard = 0;
            do begin
              r = f_ready;
              @(negedge clk);
              guard++;
            end while (!r && guard < 100);
          end
        end
        f_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          f_wreq = 1'($urandom_range(0, 1));
          #1;
          if (f_wr && !f_wreq) nwr++;
          if (f_fd) begin
            nfd++;
            fd_ok = f_wr && !f_wreq && (f_wd[31:22] == 10'd3) && (f_wd[21:12] == 10'd7)
                    && (f_pc == 20'd31);
          end
          @(negedge clk);
          if (nwr == 32) begin
            post++;
            if (post > 5) break;
          end
        end
        f_wreq = 1'b0;
      end
    join
    check("frame_write_count", nwr, 32);
    check("frame_done_pulses", nfd, 1);
    check("frame_done_on_last", fd_ok, 1);
    check("frame_pixel_count_zero", f_pc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
